// File: rtl/lab3_mem_cache_base_ctrl.sv
// Control unit for the lab3 blocking cache: one request at a time, write-back/write-allocate,
// direct-mapped with 16 lines. Owns the valid/dirty state; tags and data live in the datapath.
module lab3_mem_cache_base_ctrl #(
    parameter int unsigned p_num_banks = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        proc2cache_reqstream_val,
    output logic        proc2cache_reqstream_rdy,
    output logic        proc2cache_respstream_val,
    input  logic        proc2cache_respstream_rdy,

    output logic        cache2mem_reqstream_val,
    input  logic        cache2mem_reqstream_rdy,
    input  logic        cache2mem_respstream_val,
    output logic        cache2mem_respstream_rdy,

    input  logic [2:0]  cachereq_type,
    input  logic [31:0] cachereq_addr,
    input  logic        tag_match,

    output logic        cachereq_reg_en,
    output logic        tag_array_ren,
    output logic        tag_array_wen,
    output logic        evict_addr_reg_en,
    output logic        memreq_addr_mux_sel,
    output logic        memresp_reg_en,
    output logic        write_data_mux_sel,
    output logic        wben_mux_sel,
    output logic        data_array_ren,
    output logic        data_array_wen,
    output logic        read_data_zero_mux_sel,
    output logic        read_data_reg_en,

    output logic [2:0]  cacheresp_type,
    output logic [1:0]  hit_WAIT,
    output logic [2:0]  memreq_type
);

    // With four banks, address bits [5:4] select the bank, so the line index moves up by two.
    localparam int unsigned IdxLsb = (p_num_banks == 4) ? 6 : 4;

    if (!(p_num_banks == 1 || p_num_banks == 4)) begin : g_bad_banks
        $error("p_num_banks must be 1 or 4");
    end

    localparam logic [2:0] TypeRead  = 3'd0;
    localparam logic [2:0] TypeWrite = 3'd1;
    localparam logic [2:0] TypeInit  = 3'd2;

    typedef enum logic [3:0] {
        StIdle,
        StTc,
        StIn,
        StRd,
        StWd,
        StEp,
        StEr,
        StEw,
        StRr,
        StRw,
        StRu,
        StWt
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] valid_q, valid_d;
    logic [15:0] dirty_q, dirty_d;
    logic        hit_q, hit_d;
    logic [2:0]  type_q, type_d;

    logic [3:0]  idx;
    logic        hit;
    logic        unused_addr;

    assign idx         = cachereq_addr[IdxLsb +: 4];
    assign hit         = valid_q[idx] && tag_match;
    assign unused_addr = ^cachereq_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
            hit_q   <= 1'b0;
            type_q  <= TypeRead;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            hit_q   <= hit_d;
            type_q  <= type_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        hit_d   = hit_q;
        type_d  = type_q;

        proc2cache_reqstream_rdy  = 1'b0;
        proc2cache_respstream_val = 1'b0;
        cache2mem_reqstream_val   = 1'b0;
        cache2mem_respstream_rdy  = 1'b0;
        cachereq_reg_en           = 1'b0;
        tag_array_ren             = 1'b0;
        tag_array_wen             = 1'b0;
        evict_addr_reg_en         = 1'b0;
        memreq_addr_mux_sel       = 1'b0;
        memresp_reg_en            = 1'b0;
        write_data_mux_sel        = 1'b0;
        wben_mux_sel              = 1'b0;
        data_array_ren            = 1'b0;
        data_array_wen            = 1'b0;
        read_data_zero_mux_sel    = 1'b0;
        read_data_reg_en          = 1'b0;
        cacheresp_type            = 3'd0;
        hit_WAIT                  = 2'd0;
        memreq_type               = 3'd0;

        // Outputs stay quiet while reset is held, whatever the stale state register says.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    proc2cache_reqstream_rdy = 1'b1;
                    cachereq_reg_en          = 1'b1;
                    if (proc2cache_reqstream_val) begin
                        state_d = StTc;
                    end
                end
                StTc: begin
                    tag_array_ren = 1'b1;
                    hit_d         = hit;
                    type_d        = cachereq_type;
                    if (cachereq_type == TypeInit) begin
                        state_d = StIn;
                    end else if (hit) begin
                        state_d = (cachereq_type == TypeWrite) ? StWd : StRd;
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = StEp;
                    end else begin
                        state_d = StRr;
                    end
                end
                StIn: begin
                    tag_array_wen  = 1'b1;
                    data_array_wen = 1'b1;
                    valid_d[idx]   = 1'b1;
                    dirty_d[idx]   = 1'b0;
                    state_d        = StWt;
                end
                StRd: begin
                    data_array_ren   = 1'b1;
                    read_data_reg_en = 1'b1;
                    state_d          = StWt;
                end
                StWd: begin
                    data_array_wen = 1'b1;
                    dirty_d[idx]   = 1'b1;
                    state_d        = StWt;
                end
                StEp: begin
                    tag_array_ren     = 1'b1;
                    data_array_ren    = 1'b1;
                    read_data_reg_en  = 1'b1;
                    evict_addr_reg_en = 1'b1;
                    state_d           = StEr;
                end
                StEr: begin
                    cache2mem_reqstream_val = 1'b1;
                    memreq_type             = 3'd1;
                    if (cache2mem_reqstream_rdy) begin
                        state_d = StEw;
                    end
                end
                StEw: begin
                    cache2mem_respstream_rdy = 1'b1;
                    if (cache2mem_respstream_val) begin
                        state_d = StRr;
                    end
                end
                StRr: begin
                    cache2mem_reqstream_val = 1'b1;
                    memreq_addr_mux_sel     = 1'b1;
                    if (cache2mem_reqstream_rdy) begin
                        state_d = StRw;
                    end
                end
                StRw: begin
                    cache2mem_respstream_rdy = 1'b1;
                    memresp_reg_en           = 1'b1;
                    if (cache2mem_respstream_val) begin
                        state_d = StRu;
                    end
                end
                StRu: begin
                    tag_array_wen      = 1'b1;
                    data_array_wen     = 1'b1;
                    write_data_mux_sel = 1'b1;
                    wben_mux_sel       = 1'b1;
                    valid_d[idx]       = 1'b1;
                    dirty_d[idx]       = 1'b0;
                    state_d            = (type_q == TypeWrite) ? StWd : StRd;
                end
                StWt: begin
                    proc2cache_respstream_val = 1'b1;
                    cacheresp_type            = type_q;
                    hit_WAIT                  = {1'b0, hit_q};
                    if (proc2cache_respstream_rdy) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_mem_cache_base_ctrl.sv
// Directed bench for the cache controller: the bench plays processor, tag datapath and memory,
// and checks handshake timing, state-visit counts and memory request ordering per transaction.
module tb_lab3_mem_cache_base_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        sel4 = 1'b0;
    logic        req_val = 1'b0;
    logic        resp_rdy = 1'b1;
    logic        mreq_rdy = 1'b1;
    logic        mresp_val = 1'b0;
    logic        tag_match = 1'b0;
    logic [2:0]  req_type = 3'd0;
    logic [31:0] req_addr = 32'd0;

    wire [23:0] obs1, obs4, obs;
    wire        o_req_rdy, o_resp_val, o_mreq_val, o_addr_sel, o_mresp_rdy, o_mresp_en;
    wire        o_tag_wen, o_data_wen, o_wdata_sel, o_wben_sel, o_tag_ren, o_data_ren;
    wire        o_rd_en, o_zero_sel, o_evict_en, o_creq_en;
    wire [2:0]  o_mreq_type, o_cresp_type;
    wire [1:0]  o_hit;

    assign obs = sel4 ? obs4 : obs1;
    assign {o_req_rdy, o_resp_val, o_mreq_val, o_mreq_type, o_addr_sel, o_mresp_rdy, o_mresp_en,
            o_tag_wen, o_data_wen, o_wdata_sel, o_wben_sel, o_tag_ren, o_data_ren, o_rd_en,
            o_zero_sel, o_evict_en, o_creq_en, o_cresp_type, o_hit} = obs;

    lab3_mem_cache_base_ctrl #(.p_num_banks(1)) dut1 (
        .clk                       (clk),
        .reset                     (reset | sel4),
        .proc2cache_reqstream_val  (req_val),
        .proc2cache_reqstream_rdy  (obs1[23]),
        .proc2cache_respstream_val (obs1[22]),
        .proc2cache_respstream_rdy (resp_rdy),
        .cache2mem_reqstream_val   (obs1[21]),
        .cache2mem_reqstream_rdy   (mreq_rdy),
        .cache2mem_respstream_val  (mresp_val),
        .cache2mem_respstream_rdy  (obs1[16]),
        .cachereq_type             (req_type),
        .cachereq_addr             (req_addr),
        .tag_match                 (tag_match),
        .cachereq_reg_en           (obs1[5]),
        .tag_array_ren             (obs1[10]),
        .tag_array_wen             (obs1[14]),
        .evict_addr_reg_en         (obs1[6]),
        .memreq_addr_mux_sel       (obs1[17]),
        .memresp_reg_en            (obs1[15]),
        .write_data_mux_sel        (obs1[12]),
        .wben_mux_sel              (obs1[11]),
        .data_array_ren            (obs1[9]),
        .data_array_wen            (obs1[13]),
        .read_data_zero_mux_sel    (obs1[7]),
        .read_data_reg_en          (obs1[8]),
        .cacheresp_type            (obs1[4:2]),
        .hit_WAIT                  (obs1[1:0]),
        .memreq_type               (obs1[20:18])
    );

    lab3_mem_cache_base_ctrl #(.p_num_banks(4)) dut4 (
        .clk                       (clk),
        .reset                     (reset | ~sel4),
        .proc2cache_reqstream_val  (req_val),
        .proc2cache_reqstream_rdy  (obs4[23]),
        .proc2cache_respstream_val (obs4[22]),
        .proc2cache_respstream_rdy (resp_rdy),
        .cache2mem_reqstream_val   (obs4[21]),
        .cache2mem_reqstream_rdy   (mreq_rdy),
        .cache2mem_respstream_val  (mresp_val),
        .cache2mem_respstream_rdy  (obs4[16]),
        .cachereq_type             (req_type),
        .cachereq_addr             (req_addr),
        .tag_match                 (tag_match),
        .cachereq_reg_en           (obs4[5]),
        .tag_array_ren             (obs4[10]),
        .tag_array_wen             (obs4[14]),
        .evict_addr_reg_en         (obs4[6]),
        .memreq_addr_mux_sel       (obs4[17]),
        .memresp_reg_en            (obs4[15]),
        .write_data_mux_sel        (obs4[12]),
        .wben_mux_sel              (obs4[11]),
        .data_array_ren            (obs4[9]),
        .data_array_wen            (obs4[13]),
        .read_data_zero_mux_sel    (obs4[7]),
        .read_data_reg_en          (obs4[8]),
        .cacheresp_type            (obs4[4:2]),
        .hit_WAIT                  (obs4[1:0]),
        .memreq_type               (obs4[20:18])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-transaction observations, filled in by run_req.
    int         r_lat, r_nmr, r_nru, r_nrd, r_nwd, r_nin, r_nep, r_nval, r_bad, r_nresp;
    logic [1:0] r_hit;
    logic [2:0] r_type;
    logic [2:0] mr_type [4];
    logic       mr_sel [4];

    task automatic do_reset();
        reset     = 1'b1;
        req_val   = 1'b0;
        mresp_val = 1'b0;
        resp_rdy  = 1'b1;
        step();
        step();
        check("rst_outputs_zero", {8'd0, obs}, 32'd0);
        reset = 1'b0;
        step();
        check("rst_release_rdy", {31'd0, o_req_rdy}, 32'd1);
        check("rst_release_reg_en", {31'd0, o_creq_en}, 32'd1);
    endtask

    task automatic run_req(input logic [2:0] typ, input logic [31:0] addr, input logic tm,
                           input int mem_lat, input int hold);
        int  wait_c;
        int  wcnt;
        int  hold_left;
        bit  outstanding;
        bit  done;
        bit  mreq_fire, mresp_fire, presp_fire;
        r_lat = 0; r_nmr = 0; r_nru = 0; r_nrd = 0; r_nwd = 0; r_nin = 0; r_nep = 0;
        r_nval = 0; r_bad = 0; r_nresp = 0; r_hit = 2'd3; r_type = 3'd7;
        for (int i = 0; i < 4; i++) begin
            mr_type[i] = 3'd7;
            mr_sel[i]  = 1'b0;
        end
        wait_c = 0;
        while (!o_req_rdy && wait_c < 20) begin
            step();
            wait_c++;
        end
        check("accept_rdy", {31'd0, o_req_rdy}, 32'd1);
        req_val   = 1'b1;
        req_type  = typ;
        req_addr  = addr;
        tag_match = tm;
        hold_left = hold;
        resp_rdy  = (hold == 0);
        outstanding = 1'b0;
        wcnt      = 0;
        mresp_val = 1'b0;
        done      = 1'b0;
        step();
        req_val = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            mreq_fire  = o_mreq_val && mreq_rdy;
            mresp_fire = mresp_val && o_mresp_rdy;
            presp_fire = o_resp_val && resp_rdy;
            if (o_req_rdy) r_bad++;
            if (mreq_fire) begin
                if (r_nmr < 4) begin
                    mr_type[r_nmr] = o_mreq_type;
                    mr_sel[r_nmr]  = o_addr_sel;
                end
                r_nmr++;
            end
            if (o_tag_wen && o_data_wen && o_wben_sel && o_wdata_sel) r_nru++;
            if (o_data_ren && o_rd_en && !o_tag_ren && !o_zero_sel) r_nrd++;
            if (o_data_wen && !o_tag_wen && !o_wben_sel && !o_wdata_sel) r_nwd++;
            if (o_tag_wen && o_data_wen && !o_wben_sel && !o_wdata_sel) r_nin++;
            if (o_evict_en && o_tag_ren && o_data_ren && o_rd_en) r_nep++;
            if (o_resp_val) begin
                r_nval++;
                if (r_lat == 0) begin
                    r_lat  = c + 1;
                    r_hit  = o_hit;
                    r_type = o_cresp_type;
                end
            end
            if (presp_fire) begin
                r_nresp++;
                done = 1'b1;
            end
            step();
            if (outstanding && wcnt > 0) wcnt--;
            if (mresp_fire) outstanding = 1'b0;
            if (mreq_fire) begin
                outstanding = 1'b1;
                wcnt = mem_lat;
            end
            mresp_val = outstanding && (wcnt == 0);
            if (r_nval > 0 && hold_left > 0) hold_left--;
            resp_rdy = (hold_left == 0);
        end
        check("txn_done", {31'd0, done}, 32'd1);
        mresp_val = 1'b0;
        resp_rdy  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (o_resp_val) r_nresp++;
            step();
        end
    endtask

    task automatic expect_txn(input string tag, input int lat, input logic [1:0] hit,
                              input logic [2:0] typ, input int nmr, input int nru,
                              input int nrd, input int nwd, input int nin, input int nep);
        check({tag, "_lat"}, r_lat, lat);
        check({tag, "_hit"}, {30'd0, r_hit}, {30'd0, hit});
        check({tag, "_type"}, {29'd0, r_type}, {29'd0, typ});
        check({tag, "_nmemreq"}, r_nmr, nmr);
        check({tag, "_nru"}, r_nru, nru);
        check({tag, "_nrd"}, r_nrd, nrd);
        check({tag, "_nwd"}, r_nwd, nwd);
        check({tag, "_nin"}, r_nin, nin);
        check({tag, "_nep"}, r_nep, nep);
        check({tag, "_busy_rdy"}, r_bad, 0);
        check({tag, "_nresp"}, r_nresp, 1);
    endtask

    initial begin
        int c;
        do_reset();

        // Empty cache, tag_match forced high: invalid line must still miss.
        run_req(3'd0, 32'h0000_2000, 1'b1, 2, 0);
        expect_txn("cold_rd", 8, 2'd0, 3'd0, 1, 1, 1, 0, 0, 0);
        check("cold_rd_mr_type", {29'd0, mr_type[0]}, 32'd0);
        check("cold_rd_mr_sel", {31'd0, mr_sel[0]}, 32'd1);

        run_req(3'd0, 32'h0000_0010, 1'b1, 0, 0);
        expect_txn("idx1_rd", 6, 2'd0, 3'd0, 1, 1, 1, 0, 0, 0);

        run_req(3'd2, 32'h0000_1000, 1'b0, 0, 0);
        expect_txn("init_1000", 3, 2'd0, 3'd2, 0, 0, 0, 0, 1, 0);

        run_req(3'd0, 32'h0000_1000, 1'b1, 0, 0);
        expect_txn("hit_rd", 3, 2'd1, 3'd0, 0, 0, 1, 0, 0, 0);

        run_req(3'd2, 32'h0000_0000, 1'b0, 0, 0);
        expect_txn("init_0000", 3, 2'd0, 3'd2, 0, 0, 0, 0, 1, 0);

        run_req(3'd1, 32'h0000_0000, 1'b1, 0, 0);
        expect_txn("hit_wr", 3, 2'd1, 3'd1, 0, 0, 0, 1, 0, 0);

        // Dirty line at index 0: writeback must precede the refill.
        run_req(3'd0, 32'h0000_0100, 1'b0, 0, 0);
        expect_txn("dirty_rd", 9, 2'd0, 3'd0, 2, 1, 1, 0, 0, 1);
        check("dirty_mr0_type", {29'd0, mr_type[0]}, 32'd1);
        check("dirty_mr0_sel", {31'd0, mr_sel[0]}, 32'd0);
        check("dirty_mr1_type", {29'd0, mr_type[1]}, 32'd0);
        check("dirty_mr1_sel", {31'd0, mr_sel[1]}, 32'd1);

        run_req(3'd1, 32'h0000_0300, 1'b0, 1, 0);
        expect_txn("clean_wr_miss", 7, 2'd0, 3'd1, 1, 1, 0, 1, 0, 0);

        run_req(3'd0, 32'h0000_0300, 1'b1, 0, 5);
        expect_txn("resp_stall", 3, 2'd1, 3'd0, 0, 0, 1, 0, 0, 0);
        check("resp_stall_val_cycles", r_nval, 6);

        // Reset while waiting for the refill response.
        while (!o_req_rdy) step();
        req_val   = 1'b1;
        req_type  = 3'd0;
        req_addr  = 32'h0000_0010;
        tag_match = 1'b0;
        mresp_val = 1'b0;
        step();
        req_val = 1'b0;
        c = 0;
        while (!(o_mresp_en && o_mresp_rdy) && c < 20) begin
            step();
            c++;
        end
        check("rw_reached", {31'd0, o_mresp_en}, 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_outputs_zero", {8'd0, obs}, 32'd0);
        reset = 1'b0;
        step();
        check("mid_rst_idle_rdy", {31'd0, o_req_rdy}, 32'd1);
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_resp_val) c++;
            step();
        end
        check("mid_rst_no_resp", c, 0);
        // Index 0 was valid and dirty before reset; now it must be a clean miss.
        run_req(3'd0, 32'h0000_0000, 1'b1, 0, 0);
        expect_txn("post_rst_rd", 6, 2'd0, 3'd0, 1, 1, 1, 0, 0, 0);

        // Four-bank instance: 0x240 maps to index 9.
        sel4 = 1'b1;
        do_reset();
        run_req(3'd0, 32'h0000_0240, 1'b0, 0, 0);
        expect_txn("b4_refill", 6, 2'd0, 3'd0, 1, 1, 1, 0, 0, 0);
        check("b4_refill_sel", {31'd0, mr_sel[0]}, 32'd1);
        run_req(3'd0, 32'h0000_0200, 1'b1, 0, 0);
        expect_txn("b4_idx8", 6, 2'd0, 3'd0, 1, 1, 1, 0, 0, 0);
        run_req(3'd0, 32'h0000_0250, 1'b1, 0, 0);
        expect_txn("b4_idx9_hit", 3, 2'd1, 3'd0, 0, 0, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
